accum32_stream: RTL and testbench



---
 rtl/arith_pkg.sv | 14 +
 rtl/adder32.sv | 15 +
 rtl/accum32_stream.sv | 96 +++++++++
 tb/tb_accum32_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic examples datapath.
// Holds the accumulator state encoding and the default widths.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } accum_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/adder32.sv
// Plain modulo-2^WIDTH adder with no carry output.
// The sum wraps silently when it overflows.
module adder32
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/accum32_stream.sv
// Streaming multi-operand accumulator built around a single adder32.
// It sums a burst of operands and holds the total plus a carry count until the result is taken.
module accum32_stream
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [WIDTH-1:0] op_data_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_sum_o,
    output logic [CNT_W-1:0] res_carry_o,
    output logic             busy_o
);

    accum_state_t     state;
    accum_state_t     state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] carry_cnt;
    logic             handshake;

    adder32 #(.WIDTH(WIDTH)) u_add (
        .a_i   (acc),
        .b_i   (op_data_i),
        .sum_o (sum_next)
    );

    // Ready depends only on the state register, so there is no path from op_valid_i.
    assign op_ready_o = (state == ACCUM);
    assign handshake  = op_valid_i & op_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (handshake && (remaining == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The adder has no carry port, so a wrap is spotted as the new sum falling below the old total.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc       <= '0;
            remaining <= '0;
            carry_cnt <= '0;
        end else if ((state == IDLE) && start_i) begin
            acc       <= '0;
            remaining <= len_i;
            carry_cnt <= '0;
        end else if (handshake) begin
            acc       <= sum_next;
            remaining <= remaining - CNT_W'(1);
            if ((sum_next < acc) && (carry_cnt != '1)) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

    // Result fields are gated so that a partial sum never appears on the result interface.
    assign res_valid_o = (state == DONE);
    assign res_sum_o   = res_valid_o ? acc : '0;
    assign res_carry_o = res_valid_o ? carry_cnt : '0;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_accum32_stream.sv
// Self-checking bench for accum32_stream: fixed vectors, randomised bursts against a
// plain-arithmetic reference, and hand-written sequences for the multi-cycle corner cases.
module tb_accum32_stream;
    import arith_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  len_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [31:0] op_data_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_sum_o;
    logic [7:0]  res_carry_o;
    logic        busy_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] opq[$];

    typedef struct {
        int          len;
        logic [31:0] ops [3];
        int          gap;
        logic [31:0] exp_sum;
        logic [7:0]  exp_carry;
    } vec_t;

    vec_t tbl [3];

    always #5 clk_i = ~clk_i;

    accum32_stream dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_data_i   (op_data_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_sum_o   (res_sum_o),
        .res_carry_o (res_carry_o),
        .busy_o      (busy_o)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: true 33-bit sum per operand; every overflow past 2^32 is one carry, capped at all-ones.
    task automatic model(input int len, output logic [31:0] s, output logic [7:0] c);
        longint t;
        s = 32'h0;
        c = 8'h0;
        for (int i = 0; i < len; i++) begin
            t = longint'(s) + longint'(opq[i]);
            if (t >= 64'h1_0000_0000 && c != 8'hFF) c = c + 8'h1;
            s = t[31:0];
        end
    endtask

    task automatic apply_stimulus(input int len, input int gap, input int res_delay,
                                  input logic [31:0] exp_sum, input logic [7:0] exp_carry,
                                  input string tag);
        start_i = 1'b1;
        len_i   = len[7:0];
        step();
        start_i = 1'b0;
        if (len == 0) begin
            check_output({tag, ":len0_valid"}, 32'(res_valid_o), 32'h1);
            check_output({tag, ":len0_ready"}, 32'(op_ready_o), 32'h0);
        end else begin
            check_output({tag, ":ready_lat"}, 32'(op_ready_o), 32'h1);
            check_output({tag, ":busy"}, 32'(busy_o), 32'h1);
        end
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap; g++) begin
                op_valid_i = 1'b0;
                step();
                check_output({tag, ":gap_ready"}, 32'(op_ready_o), 32'h1);
                check_output({tag, ":gap_valid"}, 32'(res_valid_o), 32'h0);
            end
            op_valid_i = 1'b1;
            op_data_i  = opq[i];
            step();
            op_valid_i = 1'b0;
            op_data_i  = $urandom();
        end
        check_output({tag, ":res_valid"}, 32'(res_valid_o), 32'h1);
        check_output({tag, ":sum"}, res_sum_o, exp_sum);
        check_output({tag, ":carry"}, 32'(res_carry_o), 32'(exp_carry));
        for (int d = 0; d < res_delay; d++) begin
            step();
            check_output({tag, ":hold_valid"}, 32'(res_valid_o), 32'h1);
            check_output({tag, ":hold_sum"}, res_sum_o, exp_sum);
        end
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check_output({tag, ":idle_busy"}, 32'(busy_o), 32'h0);
        check_output({tag, ":idle_valid"}, 32'(res_valid_o), 32'h0);
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0]  c;
        int          len;

        tbl[0] = '{len: 3, ops: '{32'h0000_0000, 32'h0000_1001, 32'h0000_A00A}, gap: 0,
                   exp_sum: 32'h0000_B00B, exp_carry: 8'd0};
        tbl[1] = '{len: 2, ops: '{32'h0000_0001, 32'h0000_FFFF, 32'h0}, gap: 2,
                   exp_sum: 32'h0001_0000, exp_carry: 8'd0};
        tbl[2] = '{len: 3, ops: '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF}, gap: 0,
                   exp_sum: 32'h0000_0000, exp_carry: 8'd2};

        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_i       = 8'h0;
        op_valid_i  = 1'b0;
        op_data_i   = 32'h0;
        res_ready_i = 1'b0;
        step();
        step();
        check_output("reset_ready", 32'(op_ready_o), 32'h0);
        check_output("reset_valid", 32'(res_valid_o), 32'h0);
        check_output("reset_sum", res_sum_o, 32'h0);
        check_output("reset_carry", 32'(res_carry_o), 32'h0);
        check_output("reset_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;
        step();

        for (int v = 0; v < 3; v++) begin
            opq.delete();
            for (int i = 0; i < tbl[v].len; i++) opq.push_back(tbl[v].ops[i]);
            apply_stimulus(tbl[v].len, tbl[v].gap, 1, tbl[v].exp_sum, tbl[v].exp_carry,
                           $sformatf("tbl%0d", v));
        end

        // len=0 goes straight to DONE and never takes an operand
        start_i    = 1'b1;
        len_i      = 8'h0;
        op_valid_i = 1'b1;
        op_data_i  = 32'hDEAD_BEEF;
        step();
        start_i = 1'b0;
        check_output("len0_valid", 32'(res_valid_o), 32'h1);
        check_output("len0_ready", 32'(op_ready_o), 32'h0);
        check_output("len0_sum", res_sum_o, 32'h0);
        check_output("len0_carry", 32'(res_carry_o), 32'h0);
        step();
        check_output("len0_sum_hold", res_sum_o, 32'h0);
        op_valid_i  = 1'b0;
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check_output("len0_idle", 32'(busy_o), 32'h0);

        // result backpressure with a start pulse that must be ignored
        opq = '{32'h0000_0077, 32'h0000_0100};
        start_i = 1'b1;
        len_i   = 8'd2;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid_i = 1'b1;
            op_data_i  = opq[i];
            step();
        end
        op_valid_i = 1'b0;
        for (int d = 0; d < 5; d++) begin
            start_i = (d == 1);
            len_i   = 8'd3;
            check_output("bp_valid", 32'(res_valid_o), 32'h1);
            check_output("bp_sum", res_sum_o, 32'h0000_0177);
            step();
        end
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check_output("bp_idle", 32'(busy_o), 32'h0);
        step();
        check_output("bp_no_queue", 32'(op_ready_o), 32'h0);

        // reset in the middle of a burst drops the partial sum
        start_i = 1'b1;
        len_i   = 8'd4;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid_i = 1'b1;
            op_data_i  = 32'h1000_0000 + 32'(i);
            step();
        end
        op_valid_i = 1'b0;
        rst_i      = 1'b1;
        step();
        rst_i = 1'b0;
        check_output("rst_busy", 32'(busy_o), 32'h0);
        check_output("rst_ready", 32'(op_ready_o), 32'h0);
        check_output("rst_valid", 32'(res_valid_o), 32'h0);
        check_output("rst_sum", res_sum_o, 32'h0);
        opq = '{32'h0000_0005};
        apply_stimulus(1, 0, 0, 32'h5, 8'h0, "post_rst");

        // randomised bursts against the arithmetic reference
        for (int k = 0; k < 30; k++) begin
            len = (k % 10 == 9) ? 0 : int'($urandom_range(1, 12));
            opq.delete();
            for (int i = 0; i < len; i++) begin
                opq.push_back((k % 2 == 0) ? ($urandom() | 32'hC000_0000) : $urandom());
            end
            model(len, s, c);
            apply_stimulus(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), s, c,
                           $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
